sobel_row_window: RTL
=====================

// Module: sobel_row_window
// PURPOSE
//  Three-row sliding window feeding sobel_accelerator. Accepts one image row-slice per handshake
//  (NUM_ACC+2 pixels) from the input read path. Presents rows 1/2/3 (top..bottom) on srow2sacc_row*_data,
//  and advances one row per consumed window. Counts rows per column strip; pulses done when the strip ends.
// PARAMETERS
//  NUM_ACC     `NUM_SOBEL_ACCELERATORS  output pixels per window; input slice = NUM_ACC+2 pixels
//  PIX_W       8                        bits per pixel
//  ROW_CNT_W   12                       width of row counters / num_rows
//  (derived) IDATA_W = (NUM_ACC+2)*PIX_W, equals `SOBEL_IDATA_WIDTH at defaults
// PORTS
//  clk                   in   1          clock, all state on rising edge
//  rst_n                 in   1          asynchronous active-low reset
//  sctl2srow_start       in   1          1-cycle pulse: begin strip, latch num_rows
//  sctl2srow_num_rows    in   ROW_CNT_W  rows in strip (sampled on start)
//  srd2srow_valid        in   1          input row-slice valid
//  srd2srow_data         in   IDATA_W    input row-slice, pixel 0 in bits [PIX_W-1:0]
//  srow2srd_ready        out  1          block accepts slice this cycle
//  srow2sacc_valid       out  1          window on row*_data is valid
//  sacc2srow_ready       in   1          downstream consumes window this cycle
//  srow2sacc_row1_data   out  IDATA_W    oldest (top) row
//  srow2sacc_row2_data   out  IDATA_W    middle row
//  srow2sacc_row3_data   out  IDATA_W    newest (bottom) row
//  srow2sctl_done        out  1          1-cycle pulse after last window of strip consumed
// BEHAVIOUR
//  Reset: state IDLE, row1/2/3 = 0, rows_in = 0, num_rows_q = 0, done = 0; ready/valid = 0.
//  Accept = srd2srow_valid & srow2srd_ready; consume = srow2sacc_valid & sacc2srow_ready.
//  On accept: row1<=row2, row2<=row3, row3<=srd2srow_data, rows_in<=rows_in+1 (same edge).
//  Row data registers change only on accept; stable while srow2sacc_valid=1 and not consumed.
//  num_rows_q <= max(sctl2srow_num_rows, 3) on start (values 0..2 clamp to 3).
//  FSM (ready/valid are combinational from state, both forced 0 in any cycle start=1):
//   IDLE: ready=0, valid=0. start -> FILL, rows_in<=0.
//   FILL: ready=1, valid=0. accept with rows_in==2 -> WIN; else stay.
//   WIN : valid=1, ready = sacc2srow_ready & (rows_in < num_rows_q).
//         consume & rows_in==num_rows_q -> IDLE, done=1 next cycle.
//         consume & accept (same cycle) -> stay WIN (new window next cycle, zero bubble).
//         consume & no accept -> WAIT. No consume -> stay WIN, no shift.
//   WAIT: ready=1, valid=0. accept -> WIN.
//  start in any non-IDLE state: abort, rows_in<=0, -> FILL, no done pulse; row registers not cleared.
//  start has priority over any handshake in that cycle (none occurs, since ready/valid forced 0).
//  done: registered, exactly 1 cycle, once per completed strip; windows per strip = num_rows_q-2.
//  rows_in never exceeds num_rows_q; no input accepted beyond num_rows_q in a strip.
//  Async reset mid-strip: immediate return to reset values; no done pulse; restart requires start.
// TESTING
//  T1 start, num_rows=5, slices A,B,C,D,E back-to-back, ready=1 -> windows (A,B,C),(B,C,D),(C,D,E),
//     valid first high 1 cycle after C accepted; done pulses 1 cycle after 3rd consume; ready=0 after E.
//  T2 same as T1 with sacc2srow_ready low for 4 cycles on window 2 -> row data held, ready low, no loss.
//  T3 num_rows=1 -> clamped to 3: exactly 3 slices accepted, 1 window, 1 done pulse.
//  T4 start pulsed again after 4 of 8 rows accepted -> no done; FILL needs 3 new slices; window = new rows.
//  T5 rst_n low during WIN -> outputs 0 asynchronously, valid=0, ready=0; input ignored until start.
//  T6 random valid/ready stall on 64-row strip vs scoreboard -> 62 windows in order, one done pulse.

Source files
------------

// File: rtl/sobel_row_window.sv
// sobel_row_window
// Three-row sliding window in front of the Sobel accelerators. Row slices
// arrive one per handshake and shift through three row registers. Once three
// rows of a strip are held, the window (top, middle, bottom) is offered
// downstream. Each consumed window lets one new slice in, until the strip's
// row count is reached. A one-cycle done pulse marks the end of the strip.

`ifndef NUM_SOBEL_ACCELERATORS
`define NUM_SOBEL_ACCELERATORS 4
`endif

module sobel_row_window #(
  parameter int NUM_ACC   = `NUM_SOBEL_ACCELERATORS,
  parameter int PIX_W     = 8,
  parameter int ROW_CNT_W = 12,
  localparam int IDATA_W  = (NUM_ACC + 2) * PIX_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sctl2srow_start,
  input  logic [ROW_CNT_W-1:0] sctl2srow_num_rows,
  input  logic                 srd2srow_valid,
  input  logic [IDATA_W-1:0]   srd2srow_data,
  output logic                 srow2srd_ready,
  output logic                 srow2sacc_valid,
  input  logic                 sacc2srow_ready,
  output logic [IDATA_W-1:0]   srow2sacc_row1_data,
  output logic [IDATA_W-1:0]   srow2sacc_row2_data,
  output logic [IDATA_W-1:0]   srow2sacc_row3_data,
  output logic                 srow2sctl_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_WIN  = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  // A strip shorter than three rows still needs three rows to form a window.
  localparam logic [ROW_CNT_W-1:0] MIN_ROWS = ROW_CNT_W'(3);
  localparam logic [ROW_CNT_W-1:0] LAST_FILL = ROW_CNT_W'(2);

  state_t                 r_state;
  state_t                 w_state_next;
  logic [ROW_CNT_W-1:0]   r_rows_in;
  logic [ROW_CNT_W-1:0]   r_num_rows_q;
  logic [ROW_CNT_W-1:0]   w_num_rows_clamped;
  logic [IDATA_W-1:0]     r_row1;
  logic [IDATA_W-1:0]     r_row2;
  logic [IDATA_W-1:0]     r_row3;
  logic                   r_done;
  logic                   w_done_next;
  logic                   w_ready;
  logic                   w_valid;
  logic                   w_accept;
  logic                   w_consume;
  logic                   w_last_row_in;

  assign w_num_rows_clamped = (sctl2srow_num_rows < MIN_ROWS) ? MIN_ROWS : sctl2srow_num_rows;
  assign w_last_row_in      = (r_rows_in == r_num_rows_q);
  assign w_accept           = srd2srow_valid & w_ready;
  assign w_consume          = w_valid & sacc2srow_ready;

  // Handshake outputs decoded from state; a start pulse blocks both handshakes.
  always_comb begin
    w_ready = 1'b0;
    w_valid = 1'b0;
    if (!sctl2srow_start) begin
      case (r_state)
        S_FILL:  w_ready = 1'b1;
        S_WAIT:  w_ready = 1'b1;
        S_WIN: begin
          w_valid = 1'b1;
          // Only pull a new row when the current window leaves in the same
          // cycle, and never beyond the strip length.
          w_ready = sacc2srow_ready & (r_rows_in < r_num_rows_q);
        end
        default: ;
      endcase
    end
  end

  // Next-state decode and end-of-strip detection.
  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    if (sctl2srow_start) begin
      w_state_next = S_FILL;
    end else begin
      case (r_state)
        S_IDLE: ;
        S_FILL: begin
          if (w_accept && (r_rows_in == LAST_FILL)) begin
            w_state_next = S_WIN;
          end
        end
        S_WIN: begin
          if (w_consume) begin
            if (w_last_row_in) begin
              w_state_next = S_IDLE;
              w_done_next  = 1'b1;
            end else if (w_accept) begin
              w_state_next = S_WIN;
            end else begin
              w_state_next = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (w_accept) begin
            w_state_next = S_WIN;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Row counter and latched strip length; start restarts counting from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rows_in    <= '0;
      r_num_rows_q <= '0;
    end else if (sctl2srow_start) begin
      r_rows_in    <= '0;
      r_num_rows_q <= w_num_rows_clamped;
    end else if (w_accept) begin
      r_rows_in    <= r_rows_in + ROW_CNT_W'(1);
    end
  end

  // Row shift: every accepted slice becomes the bottom row and the rest move up.
  // Rows are deliberately not cleared on start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row1 <= '0;
      r_row2 <= '0;
      r_row3 <= '0;
    end else if (w_accept) begin
      r_row1 <= r_row2;
      r_row2 <= r_row3;
      r_row3 <= srd2srow_data;
    end
  end

  // Registered one-cycle done pulse after the final window is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_done_next;
    end
  end

  assign srow2srd_ready      = w_ready;
  assign srow2sacc_valid     = w_valid;
  assign srow2sacc_row1_data = r_row1;
  assign srow2sacc_row2_data = r_row2;
  assign srow2sacc_row3_data = r_row3;
  assign srow2sctl_done      = r_done;

endmodule
